// File: rtl/accumulator_pkg.sv
// Shared definitions for the multi-channel accumulator: dump FSM states,
// add/subtract mode encoding and default widths.
package accumulator_pkg;

    localparam int DEFAULT_WORD_LENGTH = 8;
    localparam int DEFAULT_ACC_LENGTH  = 16;
    localparam int DEFAULT_CHANNELS    = 4;

    localparam logic ACC_ADD = 1'b0;
    localparam logic ACC_SUB = 1'b1;

    typedef enum logic [1:0] {
        IDLE,
        DUMP,
        DONE
    } dump_state_t;

endpackage

// File: rtl/accumulator_channel.sv
// One accumulation channel: add/subtract of a zero-extended operand, sticky
// carry/borrow flag, and either modular wrap or clamping on overflow.
// Optional feature: define ACCUMULATOR_SATURATE_EN to clamp instead of wrap.
module accumulator_channel
    import accumulator_pkg::*;
#(
    parameter int Acc_Length = DEFAULT_ACC_LENGTH
) (
    input  logic                  clk,
    input  logic                  n_rst,
    input  logic                  load_en,
    input  logic                  clr,
    input  logic                  sub,
    input  logic [Acc_Length-1:0] operand,
    output logic [Acc_Length-1:0] acc,
    output logic                  overflow
);

    logic [Acc_Length:0]   wide_result;
    logic                  carry;
    logic [Acc_Length-1:0] next_value;

    // Compute the next value one bit wider so the top bit is the carry/borrow.
    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path can infer a latch.
        wide_result = '0;
        if (sub == ACC_SUB) begin
            wide_result = {1'b0, acc} - {1'b0, operand};
        end else begin
            wide_result = {1'b0, acc} + {1'b0, operand};
        end
        carry      = wide_result[Acc_Length];
        next_value = wide_result[Acc_Length-1:0];
`ifdef ACCUMULATOR_SATURATE_EN
        if (carry) begin
            next_value = (sub == ACC_SUB) ? '0 : '1;
        end
`endif
    end

    // Accumulator register and sticky overflow; clear takes priority over load.
    always_ff @(posedge clk or negedge n_rst) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (!n_rst) begin
            acc      <= '0;
            overflow <= 1'b0;
        end else if (clr) begin
            acc      <= '0;
            overflow <= 1'b0;
        end else if (load_en) begin
            acc <= next_value;
            if (carry) begin
                overflow <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/multi_channel_accumulator.sv
// N-channel accumulator with a sequential dump engine that streams every
// channel's value over a valid-qualified port after a rising edge on read.
// Optional feature: define ACCUMULATOR_SATURATE_EN to clamp on overflow.
module multi_channel_accumulator
    import accumulator_pkg::*;
#(
    parameter  int Word_Length = DEFAULT_WORD_LENGTH,
    parameter  int Acc_Length  = DEFAULT_ACC_LENGTH,
    parameter  int Channels    = DEFAULT_CHANNELS,
    localparam int Chan_Bits   = $clog2(Channels)
) (
    input  logic                   clk,
    input  logic                   n_rst,
    input  logic                   enable,
    input  logic                   sub,
    input  logic [Chan_Bits-1:0]   chan_sel,
    input  logic                   clear,
    input  logic                   read,
    input  logic [Word_Length-1:0] Data_Input,
    output logic [Acc_Length-1:0]  Data_Output,
    output logic [Chan_Bits-1:0]   out_chan,
    output logic                   valid_out,
    output logic [Channels-1:0]    overflow,
    output logic                   busy
);

    localparam logic [Chan_Bits-1:0] LAST_CHAN = Chan_Bits'(Channels - 1);

    logic                  sel_valid;
    logic [Acc_Length-1:0] operand;
    logic [Acc_Length-1:0] acc_value [Channels];
    logic                  read_q;
    logic                  start;
    dump_state_t           state;
    logic [Chan_Bits-1:0]  index;

    // Out-of-range selects are dropped; the sample is zero-extended.
    assign sel_valid = (int'(chan_sel) < Channels);
    assign operand   = Acc_Length'(Data_Input);
    assign start     = read & ~read_q;

    for (genvar g = 0; g < Channels; g++) begin : g_chan
        logic hit;
        assign hit = sel_valid && (chan_sel == Chan_Bits'(g));

        accumulator_channel #(
            .Acc_Length (Acc_Length)
        ) u_channel (
            .clk      (clk),
            .n_rst    (n_rst),
            .load_en  (hit & enable),
            .clr      (hit & clear),
            .sub      (sub),
            .operand  (operand),
            .acc      (acc_value[g]),
            .overflow (overflow[g])
        );
    end

    // Register read so a level-held request produces a single start pulse.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            read_q <= 1'b0;
        end else begin
            read_q <= read;
        end
    end

    // Dump FSM: walk every channel once, then spend one cycle in DONE.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state       <= IDLE;
            index       <= '0;
            Data_Output <= '0;
            out_chan    <= '0;
            valid_out   <= 1'b0;
            busy        <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    valid_out <= 1'b0;
                    if (start) begin
                        state <= DUMP;
                        index <= '0;
                        busy  <= 1'b1;
                    end
                end
                DUMP: begin
                    Data_Output <= acc_value[index];
                    out_chan    <= index;
                    valid_out   <= 1'b1;
                    busy        <= 1'b1;
                    if (index == LAST_CHAN) begin
                        state <= DONE;
                        index <= '0;
                    end else begin
                        index <= index + 1'b1;
                    end
                end
                DONE: begin
                    valid_out <= 1'b0;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
                default: begin
                    state     <= IDLE;
                    valid_out <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_multi_channel_accumulator.sv
// Self-checking bench for multi_channel_accumulator (8-bit samples, 8-bit
// accumulators, 4 channels). Expected values come from hand tables and a
// plain-integer reference model. Honours ACCUMULATOR_SATURATE_EN.
module tb_multi_channel_accumulator;

    localparam int WL   = 8;
    localparam int AL   = 8;
    localparam int CH   = 4;
    localparam int CB   = 2;
    localparam int AMAX = (1 << AL) - 1;

    logic          clk;
    logic          n_rst;
    logic          enable;
    logic          sub;
    logic [CB-1:0] chan_sel;
    logic          clear;
    logic          read;
    logic [WL-1:0] Data_Input;
    logic [AL-1:0] Data_Output;
    logic [CB-1:0] out_chan;
    logic          valid_out;
    logic [CH-1:0] overflow;
    logic          busy;

    multi_channel_accumulator #(
        .Word_Length (WL),
        .Acc_Length  (AL),
        .Channels    (CH)
    ) dut (
        .clk         (clk),
        .n_rst       (n_rst),
        .enable      (enable),
        .sub         (sub),
        .chan_sel    (chan_sel),
        .clear       (clear),
        .read        (read),
        .Data_Input  (Data_Input),
        .Data_Output (Data_Output),
        .out_chan    (out_chan),
        .valid_out   (valid_out),
        .overflow    (overflow),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    int model_acc [CH];
    bit model_ovf [CH];
    int pre_acc   [CH];
    int got_data  [CH];

    typedef struct {
        logic          en;
        logic          sb;
        logic          clr;
        logic [CB-1:0] sel;
        logic [WL-1:0] din;
        logic [CH-1:0] exp_ovf;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic void add_vec(input logic en, input logic sb, input logic clr,
                                    input int sel, input int din, input logic [CH-1:0] exp_ovf);
        vec_t v;
        v.en = en; v.sb = sb; v.clr = clr;
        v.sel = CB'(sel); v.din = WL'(din); v.exp_ovf = exp_ovf;
        vecs.push_back(v);
    endfunction

    // Reference model: integer arithmetic, then range check against the register width.
    function automatic void model_apply();
        int sel;
        int v;
        if (!n_rst) begin
            for (int i = 0; i < CH; i++) begin
                model_acc[i] = 0;
                model_ovf[i] = 0;
            end
            return;
        end
        sel = int'(chan_sel);
        if (sel >= CH) return;
        if (clear) begin
            model_acc[sel] = 0;
            model_ovf[sel] = 0;
        end else if (enable) begin
            v = sub ? model_acc[sel] - int'(Data_Input) : model_acc[sel] + int'(Data_Input);
            if (v > AMAX || v < 0) begin
                model_ovf[sel] = 1;
`ifdef ACCUMULATOR_SATURATE_EN
                v = (v < 0) ? 0 : AMAX;
`else
                v = ((v % (AMAX + 1)) + (AMAX + 1)) % (AMAX + 1);
`endif
            end
            model_acc[sel] = v;
        end
    endfunction

    function automatic logic [CH-1:0] model_ovf_vec();
        logic [CH-1:0] r;
        for (int i = 0; i < CH; i++) r[i] = model_ovf[i];
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        pre_acc = model_acc;
        model_apply();
        #1;
    endtask

    // Pulse read, hold it for 'hold' edges, and score the whole dump window.
    task automatic run_dump(input string tag, input int hold);
        int valid_cnt;
        int busy_cnt;
        int expect_chan;
        int first_valid;
        int last_exp;
        valid_cnt = 0; busy_cnt = 0; expect_chan = 0; first_valid = -1; last_exp = 0;
        for (int i = 0; i < CH; i++) got_data[i] = -1;
        read = 1'b1;
        for (int i = 0; i < 14; i++) begin
            tick();
            if (i + 1 == hold) read = 1'b0;
            if (busy === 1'b1) busy_cnt++;
            if (valid_out === 1'b1) begin
                if (first_valid < 0) first_valid = i;
                check($sformatf("%s chan%0d idx", tag, expect_chan), out_chan, expect_chan);
                if (expect_chan < CH) begin
                    check($sformatf("%s chan%0d data", tag, expect_chan), Data_Output, pre_acc[expect_chan]);
                    got_data[expect_chan] = int'(Data_Output);
                    last_exp = pre_acc[expect_chan];
                end
                expect_chan++;
                valid_cnt++;
            end
        end
        read = 1'b0;
        check({tag, " valid_cycles"}, valid_cnt, CH);
        check({tag, " busy_cycles"}, busy_cnt, CH + 1);
        check({tag, " first_valid"}, first_valid, 1);
        check({tag, " data_hold"}, Data_Output, last_exp);
    endtask

    initial begin
        int valid_seen;

        n_rst = 1'b0; enable = 1'b0; sub = 1'b0; chan_sel = '0;
        clear = 1'b0; read = 1'b0; Data_Input = '0;
        for (int i = 0; i < CH; i++) begin
            model_acc[i] = 0;
            model_ovf[i] = 0;
        end

        // Hand-computed vectors: overflow flags after each edge.
        for (int i = 0; i < 5; i++) add_vec(1, 0, 0, 0, 3, 4'b0000);
        add_vec(1, 0, 0, 1, 200, 4'b0000);
        for (int i = 0; i < 5; i++) add_vec(1, 0, 0, 1, 200, 4'b0010);
        add_vec(1, 1, 0, 2, 1, 4'b0110);
        add_vec(0, 0, 1, 2, 0, 4'b0010);
        add_vec(1, 0, 0, 3, 7, 4'b0010);
        add_vec(0, 1, 0, 1, 99, 4'b0010);

        #12;
        check("reset valid_out", valid_out, 0);
        check("reset busy", busy, 0);
        check("reset data", Data_Output, 0);
        check("reset out_chan", out_chan, 0);
        check("reset overflow", overflow, 0);
        @(posedge clk);
        #1 n_rst = 1'b1;

        foreach (vecs[i]) begin
            enable = vecs[i].en; sub = vecs[i].sb; clear = vecs[i].clr;
            chan_sel = vecs[i].sel; Data_Input = vecs[i].din;
            tick();
            check($sformatf("vec%0d overflow", i), overflow, vecs[i].exp_ovf);
        end
        enable = 1'b0; clear = 1'b0; sub = 1'b0;

        // Read held high for 10 cycles: one dump only.
        run_dump("dump_hold", 10);
        check("plan ch0", got_data[0], 15);
`ifdef ACCUMULATOR_SATURATE_EN
        check("plan ch1", got_data[1], 255);
`else
        check("plan ch1", got_data[1], 176);
`endif
        check("plan ch2", got_data[2], 0);
        check("plan ch3", got_data[3], 7);

        // enable and clear together: clear wins.
        enable = 1'b1; clear = 1'b1; chan_sel = 2'd3; Data_Input = 8'd5;
        tick();
        check("en+clr overflow", overflow, 4'b0010);
        clear = 1'b0;

        // Keep adding 1 to ch0 through the dump; each channel reads its pre-edge value.
        chan_sel = 2'd0; Data_Input = 8'd1; sub = 1'b0; enable = 1'b1;
        run_dump("dump_busy_acc", 1);
        enable = 1'b0;
        check("busy_acc ch0", got_data[0], 16);
        check("busy_acc ch3", got_data[3], 0);

        // Randomised traffic against the model.
        for (int i = 0; i < 300; i++) begin
            enable     = 1'($urandom_range(0, 1));
            sub        = 1'($urandom_range(0, 1));
            clear      = ($urandom_range(0, 15) == 0);
            chan_sel   = CB'($urandom_range(0, CH - 1));
            Data_Input = WL'($urandom_range(0, AMAX));
            tick();
            check($sformatf("rand%0d overflow", i), overflow, model_ovf_vec());
        end
        enable = 1'b0; clear = 1'b0;
        run_dump("dump_rand", 2);

        // Force an underflow on ch1 so reset has a flag to clear.
        enable = 1'b1; sub = 1'b1; chan_sel = 2'd1; Data_Input = 8'd255;
        tick();
        tick();
        check("underflow ch1", overflow[1], 1);
        enable = 1'b0; sub = 1'b0;

        // Reset in the middle of a dump.
        read = 1'b1;
        tick();
        read = 1'b0;
        tick();
        tick();
        check("mid-dump valid before reset", valid_out, 1);
        n_rst = 1'b0;
        #1;
        check("mid-reset valid_out", valid_out, 0);
        check("mid-reset busy", busy, 0);
        check("mid-reset data", Data_Output, 0);
        check("mid-reset out_chan", out_chan, 0);
        check("mid-reset overflow", overflow, 0);
        tick();
        tick();
        n_rst = 1'b1;
        valid_seen = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (valid_out !== 1'b0 || busy !== 1'b0) valid_seen++;
        end
        check("no valid after reset", valid_seen, 0);

        run_dump("dump_after_reset", 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/multi_channel_accumulator.md
Name: multi_channel_accumulator

Overview:
- Parametrised successor to the single-channel 8-bit accumulator: N independent accumulation channels, wider accumulator registers, add/subtract mode and per-channel sticky overflow.
- Adds a sequential dump engine that streams every channel's result out over a valid-qualified output port.
- Sits between a sample source (Data_Input plus enable strobe) and a downstream consumer or debug capture block.

Parameters:
- Word_Length, 8, input sample width (unsigned).
- Acc_Length, 16, accumulator width per channel; must be >= Word_Length.
- Channels, 4, number of accumulation channels; must be >= 2.
- Chan_Bits, $clog2(Channels), channel index width (derived, not overridden).

Ports:
- clk  in  1  system clock, rising edge.
- n_rst  in  1  asynchronous active-low reset.
- enable  in  1  accumulate Data_Input into channel chan_sel this cycle.
- sub  in  1  0: acc += Data_Input; 1: acc -= Data_Input.
- chan_sel  in  Chan_Bits  target channel for enable/clear.
- clear  in  1  synchronous clear of channel chan_sel (value and overflow).
- read  in  1  rising-edge request to start a dump of all channels.
- Data_Input  in  Word_Length  sample, zero-extended to Acc_Length.
- Data_Output  out  Acc_Length  dumped accumulator value.
- out_chan  out  Chan_Bits  channel index of Data_Output.
- valid_out  out  1  Data_Output/out_chan valid this cycle.
- overflow  out  Channels  sticky per-channel overflow/underflow flags.
- busy  out  1  high while a dump is in progress.

Behaviour:
- Reset (async, n_rst=0): all accumulators 0, overflow 0, Data_Output 0, out_chan 0, valid_out 0, busy 0, FSM in IDLE, read edge detector register 0.
- Accumulate: on a clk edge with enable=1, acc[chan_sel] <= acc[chan_sel] ± zext(Data_Input). Result visible one cycle later. Other channels are unchanged.
- Overflow: an add carry-out or subtract borrow sets overflow[chan_sel]. The flag stays set until clear or reset. The value wraps modulo 2^Acc_Length.
- clear and enable together on the same channel: clear wins, giving acc=0 and overflow=0.
- chan_sel >= Channels: enable and clear are ignored.
- Read edge detection: read is registered; start = read & ~read_q. A level-held read does not retrigger.
- FSM IDLE: busy=0, valid_out=0. On start, go to DUMP with index=0.
- FSM DUMP: each cycle, Data_Output <= acc[index], out_chan <= index, valid_out <= 1, busy=1.
  - index increments each cycle.
  - After index = Channels-1, go to DONE.
  - valid_out is therefore high for exactly Channels consecutive cycles, beginning the cycle after start is registered.
- FSM DONE: one cycle, valid_out=0, busy=0, then IDLE. A new start here or in DUMP is ignored.
- Accumulation during DUMP: still allowed. A channel reads its value as of the cycle it is sampled (pre-update for that edge).
- Data_Output holds its last value when valid_out=0.
- Reset mid-dump: aborts immediately to the reset state; no further valid_out.

Optional Feature:
- Macro: ACCUMULATOR_SATURATE_EN.
- Defined: on overflow, acc clamps to 2^Acc_Length-1; on underflow, acc clamps to 0. overflow flags are still set.
- Not defined: modular wrap, as described in Behaviour.

Decomposition:
- Shared package accumulator_pkg holds:
  - FSM state enum (IDLE, DUMP, DONE);
  - mode constants ACC_ADD=1'b0 and ACC_SUB=1'b1;
  - a default width constant.
- Sub-module accumulator_channel: one accumulator register with its add/sub, overflow and saturate logic. Instantiated Channels times via generate.
- The top level owns the select decode, read edge detect and dump FSM.

Test Plan:
- Reset, then enable on ch0 with Data_Input=3 for 5 cycles -> acc[0]=15; the other channels stay 0; overflow=0.
- Add 200 six times to ch1 with Acc_Length=8 -> wrap to 1200 mod 256 = 176 and overflow[1]=1. With ACCUMULATOR_SATURATE_EN: 255 and overflow[1]=1.
- ch2 holds 0, apply sub with Data_Input=1 -> acc=255 (wrap) or 0 (saturate); overflow[2]=1. Then clear ch2 -> 0 and flag cleared.
- Channels=4 with values 15,176,0,7; pulse read and hold it high 10 cycles -> exactly 4 valid_out cycles, out_chan 0..3 with matching values, busy high 5 cycles, no retrigger.
- enable+clear on ch3 in the same cycle -> acc[3]=0; enable on ch0 during DUMP -> the dumped value reflects the cycle it was sampled.
- Assert n_rst low during DUMP cycle 2 -> all outputs 0 immediately; no further valid_out after release.
